// File: rtl/fixed_div_seq.sv
// Sequential restoring divider for signed 18.14 fixed point; one divide in flight, valid/ready on both sides.
// Define FIXED_DIV_ROUND_EN for round-to-nearest (ties away from zero); default build truncates toward zero.
module fixed_div_seq #(
  parameter int FRAC_BITS      = 14,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] numerator,
  input  logic [31:0] denominator,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int QW    = 32 + FRAC_BITS;
  localparam int ITERS = QW / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS);
  localparam int RW    = 33 + BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic          r_sign;
  logic [31:0]   r_den;
  logic [QW-1:0] r_dividend;
  logic [QW-1:0] r_quo;
  logic [RW-1:0] r_rem;
  logic [CW-1:0] r_iter;
  logic [31:0]   r_quotient;
  logic          r_dbz;
  logic          r_ovf;

  logic          w_accept;
  logic          w_lastIter;
  logic          w_take;
  logic [31:0]   w_numAbs;
  logic [31:0]   w_denAbs;
  logic [QW-1:0] w_dvdNext;
  logic [QW-1:0] w_quoNext;
  logic [RW-1:0] w_remNext;
  logic [RW-1:0] w_diff;
  logic [QW:0]   w_mag;
  logic          w_magOvf;
  logic [31:0]   w_result;
  logic          w_resDbz;
  logic          w_resOvf;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_lastIter = (r_state == CALC) && (r_iter == CW'(ITERS - 1));
  assign w_take     = (r_state == DONE) && out_ready;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  assign w_numAbs = numerator[31]   ? (~numerator + 32'd1)   : numerator;
  assign w_denAbs = denominator[31] ? (~denominator + 32'd1) : denominator;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_stateNext = CALC;
      CALC:    if (w_lastIter) w_stateNext = DONE;
      DONE:    if (out_ready)  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Restoring steps; remainder stays below |den| <= 2^31, so RW bits leave headroom for the shifted trial value.
  always_comb begin
    w_dvdNext = r_dividend;
    w_quoNext = r_quo;
    w_remNext = r_rem;
    w_diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_remNext = (w_remNext << 1) | RW'(w_dvdNext[QW-1]);
      w_dvdNext = w_dvdNext << 1;
      w_diff    = w_remNext - {{(RW-32){1'b0}}, r_den};
      if (!w_diff[RW-1]) begin
        w_remNext = w_diff;
        w_quoNext = (w_quoNext << 1) | QW'(1);
      end else begin
        w_quoNext = w_quoNext << 1;
      end
    end
  end

  always_comb begin
    w_mag = {1'b0, w_quoNext};
`ifdef FIXED_DIV_ROUND_EN
    if ({w_remNext, 1'b0} >= {{(RW+1-32){1'b0}}, r_den}) begin
      w_mag = w_mag + {{QW{1'b0}}, 1'b1};
    end
`endif
    w_magOvf = |w_mag[QW:31];
    w_resDbz = 1'b0;
    w_resOvf = 1'b0;
    if (r_den == 32'd0) begin
      w_result = 32'h7FFF_FFFF;
      w_resDbz = 1'b1;
    end else if (w_magOvf) begin
      w_result = r_sign ? 32'h8000_0001 : 32'h7FFF_FFFF;
      w_resOvf = 1'b1;
    end else begin
      w_result = r_sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sign     <= 1'b0;
      r_den      <= '0;
      r_dividend <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_iter     <= '0;
    end else if (w_accept) begin
      r_sign     <= numerator[31] ^ denominator[31];
      r_den      <= w_denAbs;
      r_dividend <= {w_numAbs, {FRAC_BITS{1'b0}}};
      r_quo      <= '0;
      r_rem      <= '0;
      r_iter     <= '0;
    end else if (r_state == CALC) begin
      r_dividend <= w_dvdNext;
      r_quo      <= w_quoNext;
      r_rem      <= w_remNext;
      r_iter     <= r_iter + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_quotient <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_lastIter) begin
      r_quotient <= w_result;
      r_dbz      <= w_resDbz;
      r_ovf      <= w_resOvf;
    end else if (w_take) begin
      r_quotient <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Scoreboard bench for fixed_div_seq: directed vectors push expectations, a negedge monitor pops and compares.
module tb_fixed_div_seq;

  localparam int FRAC    = 14;
  localparam int BPC     = 1;
  localparam int LATENCY = (32 + FRAC) / BPC + 1;

`ifdef FIXED_DIV_ROUND_EN
  localparam logic [31:0] EXP_TWO_THIRDS = 32'h0000_2AAB;
  localparam logic [31:0] EXP_HALF_LSB   = 32'h0000_0001;
  localparam logic [31:0] EXP_NEG_HALF   = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_TWO_THIRDS = 32'h0000_2AAA;
  localparam logic [31:0] EXP_HALF_LSB   = 32'h0000_0000;
  localparam logic [31:0] EXP_NEG_HALF   = 32'h0000_0000;
`endif

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b0;
  logic        in_valid    = 1'b0;
  logic        out_ready   = 1'b1;
  logic [31:0] numerator   = '0;
  logic [31:0] denominator = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        overflow;

  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
    int          acceptCycle;
    int          id;
  } exp_t;

  exp_t scoreQ[$];
  exp_t monExp;
  logic prevValid = 1'b0;

  fixed_div_seq #(
    .FRAC_BITS     (FRAC),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .numerator  (numerator),
    .denominator(denominator),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, result compare on each transfer.
  always @(negedge clock) begin
    if (!reset_n) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) begin
        if (scoreQ.size() == 0)
          checkOutput("unexpected_output", 32'(out_valid), 32'd0);
        else
          checkOutput($sformatf("latency_v%0d", scoreQ[0].id),
                      32'(cycleCount - scoreQ[0].acceptCycle), 32'(LATENCY));
      end
      if (out_valid && out_ready && scoreQ.size() > 0) begin
        monExp = scoreQ.pop_front();
        checkOutput($sformatf("quotient_v%0d", monExp.id), quotient, monExp.q);
        checkOutput($sformatf("div_by_zero_v%0d", monExp.id), 32'(div_by_zero), 32'(monExp.dbz));
        checkOutput($sformatf("overflow_v%0d", monExp.id), 32'(overflow), 32'(monExp.ovf));
      end
      prevValid = out_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] num, input logic [31:0] den, input logic [31:0] q,
                               input logic dbz, input logic ovf, input int id);
    int waited = 0;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checkOutput($sformatf("accept_timeout_v%0d", id), 32'(in_ready), 32'd1);
      return;
    end
    numerator   = num;
    denominator = den;
    in_valid    = 1'b1;
    scoreQ.push_back('{q, dbz, ovf, cycleCount, id});
    tick();
    in_valid    = 1'b0;
    numerator   = 32'hDEAD_BEEF;
    denominator = 32'h0BAD_F00D;
  endtask

  task automatic drain();
    int waited = 0;
    while (scoreQ.size() != 0 && waited < 200) begin
      tick();
      waited++;
    end
    if (scoreQ.size() != 0) begin
      checkOutput("drain_timeout", 32'(scoreQ.size()), 32'd0);
      scoreQ.delete();
    end
  endtask

  task automatic waitValid(input string name);
    int waited = 0;
    while (!out_valid && waited < 100) begin
      tick();
      waited++;
    end
    if (!out_valid) checkOutput(name, 32'(out_valid), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_quotient"}, quotient, 32'd0);
    checkOutput({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got 0x%08h, expected 0x%08h", 32'(cycleCount), 32'd0);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checkIdleOutputs("reset");
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(32'h0000_C000, 32'h0000_8000, 32'h0000_6000, 1'b0, 1'b0, 1);  drain();
    applyStimulus(32'hFFFF_C000, 32'h0000_C000, 32'hFFFF_EAAB, 1'b0, 1'b0, 2);  drain();
    applyStimulus(32'h0000_8000, 32'h0000_C000, EXP_TWO_THIRDS, 1'b0, 1'b0, 3); drain();
    applyStimulus(32'h1234_5678, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 4);  drain();
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 5);  drain();
    applyStimulus(32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b1, 6);  drain();
    applyStimulus(32'hFFFF_4000, 32'hFFFF_8000, 32'h0000_6000, 1'b0, 1'b0, 7);  drain();
    applyStimulus(32'h0000_4000, 32'hFFFF_0000, 32'hFFFF_F000, 1'b0, 1'b0, 8);  drain();
    applyStimulus(32'h0000_0000, 32'hFFFF_C000, 32'h0000_0000, 1'b0, 1'b0, 9);  drain();
    applyStimulus(32'h8000_0000, 32'h8000_0000, 32'h0000_4000, 1'b0, 1'b0, 10); drain();
    applyStimulus(32'h0000_0001, 32'h0000_8000, EXP_HALF_LSB, 1'b0, 1'b0, 11);  drain();
    applyStimulus(32'hFFFF_FFFF, 32'h0000_8000, EXP_NEG_HALF, 1'b0, 1'b0, 12);  drain();
    applyStimulus(32'h7FFF_FFFF, 32'h0000_4000, 32'h7FFF_FFFF, 1'b0, 1'b0, 13); drain();
    applyStimulus(32'h8000_0000, 32'h0000_4000, 32'h8000_0001, 1'b0, 1'b1, 14); drain();
    applyStimulus(32'h8000_0000, 32'hFFFF_C000, 32'h7FFF_FFFF, 1'b0, 1'b1, 15); drain();
    applyStimulus(32'h0001_0000, 32'h0000_0003, 32'h1555_5555, 1'b0, 1'b0, 16); drain();

    // Back-pressure: result must hold, busy inputs ignored, then release.
    out_ready = 1'b0;
    applyStimulus(32'h0000_C000, 32'h0000_8000, 32'h0000_6000, 1'b0, 1'b0, 20);
    waitValid("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_quotient", quotient, 32'h0000_6000);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_flags", {30'd0, div_by_zero, overflow}, 32'd0);
      in_valid    = (i % 2 == 1);
      numerator   = 32'h0000_4000;
      denominator = 32'h0000_4000;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkIdleOutputs("bp_release");
    drain();
    applyStimulus(32'hFFFF_C000, 32'h0000_C000, 32'hFFFF_EAAB, 1'b0, 1'b0, 21); drain();

    // Asynchronous reset during CALC: nothing stale may appear afterwards.
    applyStimulus(32'h0001_0000, 32'h0000_0003, 32'h1555_5555, 1'b0, 1'b0, 30);
    repeat (9) tick();
    #2 reset_n = 1'b0;
    #1 checkIdleOutputs("rst_calc");
    scoreQ.delete();
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("rst_calc_in_ready", 32'(in_ready), 32'd1);
    repeat (60) tick();
    applyStimulus(32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0, 31); drain();

    // Asynchronous reset while a saturated result waits in DONE.
    out_ready = 1'b0;
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 40);
    waitValid("rst_done_valid_timeout");
    #2 reset_n = 1'b0;
    #1 checkIdleOutputs("rst_done");
    scoreQ.delete();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("rst_done_in_ready", 32'(in_ready), 32'd1);
    repeat (60) tick();
    applyStimulus(32'h0000_C000, 32'h0000_8000, 32'h0000_6000, 1'b0, 1'b0, 41); drain();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
